// File: rtl/key_loader.sv
// Byte-serial key loader: assembles MSB-first bytes from the receive FIFO into
// NUM_KEYS key slots and holds the completed set until clear or reset.
module key_loader #(
  parameter int unsigned KEY_WIDTH = 64,
  parameter int unsigned NUM_KEYS  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          key_done,
  output logic [1:0]                    key_slot,
  output logic                          keys_valid,
  output logic [NUM_KEYS*KEY_WIDTH-1:0] keys_out
);

  localparam int unsigned BYTES = KEY_WIDTH / 8;
  localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
  localparam logic [1:0]    LAST_SLOT = 2'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 slot_last_byte;
  logic                 final_byte;
  logic [CW-1:0]        byte_cnt;
  logic [KEY_WIDTH-1:0] keys [NUM_KEYS];

  always_comb begin
    in_ready       = (state != DONE) && !clear;
    accept         = in_valid && in_ready;
    slot_last_byte = accept && (byte_cnt == LAST_BYTE);
    final_byte     = slot_last_byte && (key_slot == LAST_SLOT);

    state_nxt = state;
    unique case (state)
      // A single-byte, single-slot build completes on its first byte.
      IDLE:    if (accept) state_nxt = final_byte ? DONE : LOAD;
      LOAD:    if (final_byte) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt   <= '0;
      key_slot   <= '0;
      key_done   <= 1'b0;
      keys_valid <= 1'b0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) keys[k] <= '0;
    end else begin
      key_done <= slot_last_byte;
      if (final_byte) keys_valid <= 1'b1;
      if (accept) begin
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
          if (key_slot == 2'(k)) keys[k] <= (keys[k] << 8) | KEY_WIDTH'(in_data);
        end
        if (slot_last_byte) begin
          byte_cnt <= '0;
          if (!final_byte) key_slot <= key_slot + 2'd1;
        end else begin
          byte_cnt <= byte_cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    keys_out = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) keys_out[k*KEY_WIDTH +: KEY_WIDTH] = keys[k];
  end

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: a 3-slot instance driven against a byte-list model, plus
// a single-slot instance for the NUM_KEYS=1 build.
module tb_key_loader;

  localparam int TOTAL = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         key_done;
  logic [1:0]   key_slot;
  logic         keys_valid;
  logic [191:0] keys_out;

  logic         clear1 = 1'b0;
  logic [7:0]   in_data1 = '0;
  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic         key_done1;
  logic [1:0]   key_slot1;
  logic         keys_valid1;
  logic [63:0]  keys_out1;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: the list of accepted bytes and whether the last edge completed a key.
  logic [7:0] mb [TOTAL];
  int         n = 0;
  logic       exp_done = 1'b0;

  always #5 clk = ~clk;

  key_loader #(.KEY_WIDTH(64), .NUM_KEYS(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .key_done(key_done), .key_slot(key_slot),
    .keys_valid(keys_valid), .keys_out(keys_out)
  );

  key_loader #(.KEY_WIDTH(64), .NUM_KEYS(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .key_done(key_done1), .key_slot(key_slot1),
    .keys_valid(keys_valid1), .keys_out(keys_out1)
  );

  function automatic logic [191:0] model_keys();
    logic [191:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      int m;
      m = n - 8 * k;
      if (m > 8) m = 8;
      for (int j = 0; j < m; j++)
        r[k*64 +: 64] = r[k*64 +: 64] | (64'(mb[k*8+j]) << (8 * (m - 1 - j)));
    end
    return r;
  endfunction

  function automatic logic [1:0] model_slot();
    return (n / 8 > 2) ? 2'd2 : 2'(n / 8);
  endfunction

  function automatic logic model_valid();
    return n == TOTAL;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
  endtask

  task automatic tick();
    logic acc;
    acc = in_valid && !clear && (n < TOTAL);
    @(posedge clk);
    if (clear) begin
      n = 0;
      exp_done = 1'b0;
    end else if (acc) begin
      mb[n] = in_data;
      n++;
      exp_done = (n % 8 == 0);
    end else begin
      exp_done = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    exp_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (key_done !== 1'b0 || keys_valid !== 1'b0 || key_slot !== 2'd0 || keys_out !== '0) begin
      tests_failed++;
      $display("FAIL reset: done=%b valid=%b slot=%0d keys=%h, expected all zero",
               key_done, keys_valid, key_slot, keys_out);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_full_load();
    for (int i = 0; i < TOTAL; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
      tests_run++;
      if (key_done !== exp_done || key_slot !== model_slot() || keys_valid !== model_valid()) begin
        tests_failed++;
        $display("FAIL full_load byte %0d: done=%b slot=%0d valid=%b, expected done=%b slot=%0d valid=%b",
                 i + 1, key_done, key_slot, keys_valid, exp_done, model_slot(), model_valid());
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    tests_run++;
    if (keys_out[63:0] !== 64'h0001020304050607 || keys_out[191:128] !== 64'h1011121314151617 ||
        keys_out !== model_keys()) begin
      tests_failed++;
      $display("FAIL full_load_keys: got %h expected %h", keys_out, model_keys());
    end
  endtask

  task automatic test_done_hold();
    logic [191:0] snap;
    snap = model_keys();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_ready cycle %0d: in_ready=%b expected 0", i, in_ready);
      end
      tick();
      tests_run++;
      if (keys_out !== snap || keys_valid !== 1'b1 || key_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL done_hold cycle %0d: keys=%h valid=%b done=%b expected keys=%h valid=1 done=0",
                 i, keys_out, keys_valid, key_done, snap);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_gap();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
    end
    drive(1'b0, 8'hff, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (key_done !== 1'b0 || keys_out !== model_keys() || key_slot !== 2'd0) begin
        tests_failed++;
        $display("FAIL gap cycle %0d: done=%b slot=%0d keys=%h expected done=0 slot=0 keys=%h",
                 i, key_done, key_slot, keys_out, model_keys());
      end
    end
    for (int i = 4; i < TOTAL; i++) begin
      drive(1'b1, (i < 8) ? 8'(i) : 8'($urandom), 1'b0);
      tick();
      tests_run++;
      if (key_done !== exp_done || key_slot !== model_slot() || keys_out !== model_keys()) begin
        tests_failed++;
        $display("FAIL gap_resume byte %0d: done=%b slot=%0d keys=%h expected done=%b slot=%0d keys=%h",
                 i + 1, key_done, key_slot, keys_out, exp_done, model_slot(), model_keys());
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    tests_run++;
    if (keys_out[63:0] !== 64'h0001020304050607 || keys_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_slot0: slot0=%h valid=%b expected 0001020304050607 valid=1",
               keys_out[63:0], keys_valid);
    end
  endtask

  task automatic test_clear_mid();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      tick();
    end
    drive(1'b1, 8'hab, 1'b1);
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_ready: in_ready=%b expected 0", in_ready);
    end
    tick();
    tests_run++;
    if (keys_out !== '0 || key_slot !== 2'd0 || keys_valid !== 1'b0 || key_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_state: keys=%h slot=%0d valid=%b done=%b expected all zero",
               keys_out, key_slot, keys_valid, key_done);
    end
    drive(1'b1, 8'h5a, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tests_run++;
    if (keys_out !== model_keys() || keys_out[63:0] !== 64'h5a) begin
      tests_failed++;
      $display("FAIL clear_restart: keys=%h expected %h", keys_out, model_keys());
    end
  endtask

  task automatic test_rst_reload();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'($urandom) | 8'h01, 1'b0);
      tick();
    end
    do_reset();
    for (int i = 0; i < 200 && n < TOTAL; i++) begin
      drive(($urandom % 3) != 0, 8'($urandom), 1'b0);
      tick();
      tests_run++;
      if (key_done !== exp_done || key_slot !== model_slot() || keys_out !== model_keys()) begin
        tests_failed++;
        $display("FAIL rst_reload cycle %0d: done=%b slot=%0d keys=%h expected done=%b slot=%0d keys=%h",
                 i, key_done, key_slot, keys_out, exp_done, model_slot(), model_keys());
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    tests_run++;
    if (keys_valid !== 1'b1 || n != TOTAL) begin
      tests_failed++;
      $display("FAIL rst_reload_done: valid=%b bytes=%0d expected valid=1 bytes=%0d", keys_valid, n, TOTAL);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic v, c;
      v = ($urandom % 4) != 0;
      c = ($urandom % 45) == 0;
      drive(v, 8'($urandom), c);
      #1;
      tests_run++;
      if (in_ready !== ((n < TOTAL) && !c)) begin
        tests_failed++;
        $display("FAIL random_ready cycle %0d: in_ready=%b expected %b", i, in_ready, (n < TOTAL) && !c);
      end
      tick();
      tests_run++;
      if (key_done !== exp_done || key_slot !== model_slot() || keys_valid !== model_valid() ||
          keys_out !== model_keys()) begin
        tests_failed++;
        $display("FAIL random cycle %0d: done=%b slot=%0d valid=%b keys=%h expected done=%b slot=%0d valid=%b keys=%h",
                 i, key_done, key_slot, keys_valid, keys_out,
                 exp_done, model_slot(), model_valid(), model_keys());
      end
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_single_key();
    logic [63:0] w;
    logic [7:0]  b;
    w = '0;
    clear1 = 1'b1;
    @(posedge clk);
    #1;
    clear1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      w = w * 256 + 64'(b);
      in_valid1 = 1'b1;
      in_data1  = b;
      @(posedge clk);
      #1;
      tests_run++;
      if (key_done1 !== (i == 7) || keys_valid1 !== (i == 7) || key_slot1 !== 2'd0) begin
        tests_failed++;
        $display("FAIL single byte %0d: done=%b valid=%b slot=%0d expected done=%b valid=%b slot=0",
                 i + 1, key_done1, keys_valid1, key_slot1, i == 7, i == 7);
      end
    end
    in_data1 = 8'hee;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (key_done1 !== 1'b0 || keys_valid1 !== 1'b1 || in_ready1 !== 1'b0 || keys_out1 !== w ||
          key_slot1 !== 2'd0) begin
        tests_failed++;
        $display("FAIL single_hold cycle %0d: done=%b valid=%b ready=%b slot=%0d key=%h expected 0/1/0/0 key=%h",
                 i, key_done1, keys_valid1, in_ready1, key_slot1, keys_out1, w);
      end
    end
    in_valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_done_hold();
    test_gap();
    test_clear_mid();
    test_rst_reload();
    test_random();
    test_single_key();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
